// File: rtl/lab2_proc_imem_drop_unit.sv
// Imem response drop unit: gates fetch requests by credit and discards responses squashed by redirects.
// Optional LAB2_PROC_IMEM_DROP_STATS_EN adds a num_dropped counter output.
module lab2_proc_imem_drop_unit #(
  parameter int p_max_inflight = 2,
  parameter int p_resp_nbits   = 47
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    squash,
  input  logic                    req_in_val,
  output logic                    req_in_rdy,
  output logic                    req_out_val,
  input  logic                    req_out_rdy,
  input  logic [p_resp_nbits-1:0] resp_in_msg,
  input  logic                    resp_in_val,
  output logic                    resp_in_rdy,
  output logic [p_resp_nbits-1:0] resp_out_msg,
  output logic                    resp_out_val,
  input  logic                    resp_out_rdy
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
  ,
  output logic [31:0]             num_dropped
`endif
);

  localparam int CW = $clog2(p_max_inflight + 1);
  localparam logic [CW-1:0] MAX_INFLIGHT = CW'(p_max_inflight);
  localparam logic [CW-1:0] ONE          = CW'(1);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          credit;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_pop;

  // Credit uses registered inflight only, so a response's freed slot is reusable next cycle.
  assign credit      = (inflight_q < MAX_INFLIGHT);
  assign req_out_val = reset & req_in_val & credit;
  assign req_in_rdy  = reset & req_out_rdy & credit;
  assign req_fire    = req_in_val & req_in_rdy;

  assign resp_out_msg = resp_in_msg;

  always_comb begin
    resp_out_val = 1'b0;
    resp_in_rdy  = 1'b0;
    if (!reset) begin
      resp_out_val = 1'b0;
      resp_in_rdy  = 1'b0;
    end else if (squash || (drop_cnt_q != '0)) begin
      resp_out_val = 1'b0;
      resp_in_rdy  = 1'b1;
    end else begin
      resp_out_val = resp_in_val;
      resp_in_rdy  = resp_out_rdy;
    end
  end

  assign resp_fire = resp_in_val & resp_in_rdy;
  // A response with nothing outstanding is a protocol error; it never decrements below zero.
  assign resp_pop  = resp_fire & (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire) inflight_d = inflight_d + ONE;
    if (resp_pop) inflight_d = inflight_d - ONE;
  end

  // Squash marks everything already outstanding as dead; the request issued this cycle stays live.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (squash) begin
      drop_cnt_d = resp_pop ? (inflight_q - ONE) : inflight_q;
    end else if ((drop_cnt_q != '0) && resp_fire) begin
      drop_cnt_d = drop_cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
  logic [31:0] num_dropped_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_dropped_q <= '0;
    end else if (resp_fire && !resp_out_val) begin
      num_dropped_q <= num_dropped_q + 32'd1;
    end
  end

  assign num_dropped = num_dropped_q;
`endif

`ifndef SYNTHESIS
  a_drop_le_inflight : assert property (@(posedge clk) disable iff (!reset)
    (drop_cnt_q <= inflight_q) && (inflight_q <= MAX_INFLIGHT));

  a_resp_without_req : assert property (@(posedge clk) disable iff (!reset)
    !(resp_fire && (inflight_q == '0)))
    else $warning("imem drop unit: response with no outstanding request");
`endif

endmodule

// File: tb/tb_lab2_proc_imem_drop_unit.sv
// Bench for lab2_proc_imem_drop_unit: directed scenarios plus randomized traffic against a queue model.
// Define LAB2_PROC_IMEM_DROP_STATS_EN to also check num_dropped.
module tb_lab2_proc_imem_drop_unit;

  localparam int NB  = 47;
  localparam int MAX = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          squash;
  logic          req_in_val;
  logic          req_in_rdy;
  logic          req_out_val;
  logic          req_out_rdy;
  logic [NB-1:0] resp_in_msg;
  logic          resp_in_val;
  logic          resp_in_rdy;
  logic [NB-1:0] resp_out_msg;
  logic          resp_out_val;
  logic          resp_out_rdy;
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
  logic [31:0]   num_dropped;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  lab2_proc_imem_drop_unit #(.p_max_inflight(MAX), .p_resp_nbits(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .squash       (squash),
    .req_in_val   (req_in_val),
    .req_in_rdy   (req_in_rdy),
    .req_out_val  (req_out_val),
    .req_out_rdy  (req_out_rdy),
    .resp_in_msg  (resp_in_msg),
    .resp_in_val  (resp_in_val),
    .resp_in_rdy  (resp_in_rdy),
    .resp_out_msg (resp_out_msg),
    .resp_out_val (resp_out_val),
    .resp_out_rdy (resp_out_rdy)
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    ,
    .num_dropped  (num_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    squash       = 1'b0;
    req_in_val   = 1'b0;
    req_out_rdy  = 1'b1;
    resp_in_val  = 1'b0;
    resp_in_msg  = '0;
    resp_out_rdy = 1'b1;
  endtask

  // Advance to the next negedge, leave inputs as the caller sets them, then settle.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    squash = 1'b1; req_in_val = 1'b1; req_out_rdy = 1'b1;
    resp_in_val = 1'b1; resp_out_rdy = 1'b1;
    #1;
    n_cmp++;
    if ({req_in_rdy, req_out_val, resp_in_rdy, resp_out_val} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {req_in_rdy, req_out_val, resp_in_rdy, resp_out_val});
    end
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    n_cmp++;
    if (num_dropped !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_num_dropped: got %0d expected 0", num_dropped);
    end
`endif
    idle();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pass_through();
    step(); idle(); req_in_val = 1'b1; #1;
    n_cmp++;
    if ({req_out_val, req_in_rdy} !== 2'b11) begin
      n_fail++;
      $display("FAIL pass_req: got %b expected 11", {req_out_val, req_in_rdy});
    end
    step(); idle(); resp_in_val = 1'b1; resp_in_msg = NB'(32'h00000013); #1;
    n_cmp++;
    if ({resp_out_val, resp_in_rdy} !== 2'b11 || resp_out_msg !== NB'(32'h00000013)) begin
      n_fail++;
      $display("FAIL pass_resp: got val/rdy %b msg %h expected 11 msg 13",
               {resp_out_val, resp_in_rdy}, resp_out_msg);
    end
    step(); idle(); #1;
    n_cmp++;
    if (int'(dut.inflight_q) !== 0) begin
      n_fail++;
      $display("FAIL pass_inflight: got %0d expected 0", dut.inflight_q);
    end
  endtask

  task automatic test_credit_limit();
    int fires = 0;
    for (int i = 0; i < 5; i++) begin
      step(); idle(); req_in_val = 1'b1; #1;
      if (req_in_val && req_in_rdy) fires++;
    end
    n_cmp++;
    if (fires !== MAX) begin
      n_fail++;
      $display("FAIL credit_fires: got %0d expected %0d", fires, MAX);
    end
    step(); idle(); req_in_val = 1'b1; resp_in_val = 1'b1; #1;
    n_cmp++;
    if (req_in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_same_cycle: got rdy %b expected 0", req_in_rdy);
    end
    step(); idle(); req_in_val = 1'b1; #1;
    n_cmp++;
    if (req_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL credit_next_cycle: got rdy %b expected 1", req_in_rdy);
    end
    for (int i = 0; i < 2; i++) begin
      step(); idle(); resp_in_val = 1'b1;
    end
    step(); idle(); #1;
    n_cmp++;
    if (int'(dut.inflight_q) !== 0) begin
      n_fail++;
      $display("FAIL credit_drain: got inflight %0d expected 0", dut.inflight_q);
    end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 2; i++) begin
      step(); idle(); req_in_val = 1'b1;
    end
    step(); idle(); squash = 1'b1; req_in_val = 1'b1; #1;
    n_cmp++;
    if (req_in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL squash_full_rdy: got %b expected 0", req_in_rdy);
    end
    step(); idle(); #1;
    n_cmp++;
    if (int'(dut.drop_cnt_q) !== 2) begin
      n_fail++;
      $display("FAIL squash_drop_cnt: got %0d expected 2", dut.drop_cnt_q);
    end
    for (int i = 0; i < 2; i++) begin
      step(); idle(); resp_in_val = 1'b1; resp_in_msg = NB'(i + 1); #1;
      n_cmp++;
      if ({resp_out_val, resp_in_rdy} !== 2'b01) begin
        n_fail++;
        $display("FAIL squash_drop_%0d: got val/rdy %b expected 01", i, {resp_out_val, resp_in_rdy});
      end
    end
    step(); idle(); req_in_val = 1'b1;
    step(); idle(); resp_in_val = 1'b1; resp_in_msg = NB'(32'h00000093); #1;
    n_cmp++;
    if (resp_out_val !== 1'b1 || resp_out_msg !== NB'(32'h00000093)) begin
      n_fail++;
      $display("FAIL squash_live: got val %b msg %h expected 1 msg 93", resp_out_val, resp_out_msg);
    end
    // Request issued in the squash cycle must survive.
    step(); idle(); req_in_val = 1'b1;
    step(); idle(); squash = 1'b1; req_in_val = 1'b1; #1;
    n_cmp++;
    if (req_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL squash_redirect_rdy: got %b expected 1", req_in_rdy);
    end
    step(); idle(); #1;
    n_cmp++;
    if (int'(dut.drop_cnt_q) !== 1 || int'(dut.inflight_q) !== 2) begin
      n_fail++;
      $display("FAIL squash_redirect_cnt: got drop %0d inflight %0d expected 1 2",
               dut.drop_cnt_q, dut.inflight_q);
    end
    step(); idle(); resp_in_val = 1'b1;
    step(); idle(); resp_in_val = 1'b1; resp_in_msg = NB'(32'h00000093); #1;
    n_cmp++;
    if (resp_out_val !== 1'b1 || resp_out_msg !== NB'(32'h00000093)) begin
      n_fail++;
      $display("FAIL squash_redirect_live: got val %b msg %h expected 1 msg 93",
               resp_out_val, resp_out_msg);
    end
  endtask

  task automatic test_squash_coincident();
    for (int i = 0; i < 2; i++) begin
      step(); idle(); req_in_val = 1'b1;
    end
    step(); idle(); squash = 1'b1; resp_in_val = 1'b1; #1;
    n_cmp++;
    if ({resp_out_val, resp_in_rdy} !== 2'b01) begin
      n_fail++;
      $display("FAIL coinc_resp: got val/rdy %b expected 01", {resp_out_val, resp_in_rdy});
    end
    step(); idle(); #1;
    n_cmp++;
    if (int'(dut.drop_cnt_q) !== 1 || int'(dut.inflight_q) !== 1) begin
      n_fail++;
      $display("FAIL coinc_cnt: got drop %0d inflight %0d expected 1 1", dut.drop_cnt_q, dut.inflight_q);
    end
    step(); idle(); resp_in_val = 1'b1;
    step(); idle();
  endtask

  task automatic test_back_pressure();
    step(); idle(); req_in_val = 1'b1;
    step(); idle(); resp_in_val = 1'b1; resp_in_msg = NB'(47'h5A5A_1234_5678); resp_out_rdy = 1'b0; #1;
    n_cmp++;
    if ({resp_out_val, resp_in_rdy} !== 2'b10 || resp_out_msg !== NB'(47'h5A5A_1234_5678)) begin
      n_fail++;
      $display("FAIL bp_hold: got val/rdy %b msg %h expected 10", {resp_out_val, resp_in_rdy}, resp_out_msg);
    end
    step(); resp_out_rdy = 1'b1; #1;
    n_cmp++;
    if (int'(dut.inflight_q) !== 1 || resp_in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got inflight %0d rdy %b expected 1 1", dut.inflight_q, resp_in_rdy);
    end
    step(); idle(); req_in_val = 1'b1;
    step(); idle(); squash = 1'b1;
    step(); idle(); resp_in_val = 1'b1; resp_out_rdy = 1'b0; #1;
    n_cmp++;
    if ({resp_out_val, resp_in_rdy} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_drop: got val/rdy %b expected 01", {resp_out_val, resp_in_rdy});
    end
    step(); idle();
  endtask

  task automatic test_reset_mid();
    step(); idle(); req_in_val = 1'b1;
    step(); idle(); squash = 1'b1; req_in_val = 1'b1;
    step(); idle(); req_in_val = 1'b1; resp_in_val = 1'b1; #1;
    n_cmp++;
    if (int'(dut.inflight_q) !== 2 || int'(dut.drop_cnt_q) !== 1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got inflight %0d drop %0d expected 2 1", dut.inflight_q, dut.drop_cnt_q);
    end
    #1 reset = 1'b0; #1;
    n_cmp++;
    if (int'(dut.inflight_q) !== 0 || int'(dut.drop_cnt_q) !== 0 ||
        {req_in_rdy, req_out_val, resp_in_rdy, resp_out_val} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_clear: got inflight %0d drop %0d outs %b expected 0 0 0000",
               dut.inflight_q, dut.drop_cnt_q, {req_in_rdy, req_out_val, resp_in_rdy, resp_out_val});
    end
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    n_cmp++;
    if (num_dropped !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmid_num_dropped: got %0d expected 0", num_dropped);
    end
`endif
    step(); idle();
    step(); reset = 1'b1;
  endtask

  // Reference: queue of outstanding requests, oldest first, each flagged live or dead.
  task automatic test_random();
    bit         live_q[$];
    bit         any_dead, credit, e_rov, e_rir, e_pov, e_pir, rq_f, rs_f;
    logic [63:0] rnd;
    int         model_dropped = 0;
    int         n_dead;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step();
      squash       = ($urandom_range(7) == 0);
      req_in_val   = 1'($urandom_range(1));
      req_out_rdy  = ($urandom_range(3) != 0);
      resp_in_val  = (live_q.size() > 0) && ($urandom_range(1) == 1);
      rnd          = {$urandom(), $urandom()};
      resp_in_msg  = rnd[NB-1:0];
      resp_out_rdy = 1'($urandom_range(1));
      #1;
      any_dead = 1'b0;
      foreach (live_q[k]) if (!live_q[k]) any_dead = 1'b1;
      credit = (live_q.size() < MAX);
      e_rov  = req_in_val && credit;
      e_rir  = req_out_rdy && credit;
      if (squash || any_dead) begin
        e_pov = 1'b0; e_pir = 1'b1;
      end else begin
        e_pov = resp_in_val; e_pir = resp_out_rdy;
      end
      n_cmp++;
      if ({req_out_val, req_in_rdy, resp_out_val, resp_in_rdy} !== {e_rov, e_rir, e_pov, e_pir}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: got %b expected %b", c,
                 {req_out_val, req_in_rdy, resp_out_val, resp_in_rdy}, {e_rov, e_rir, e_pov, e_pir});
      end
      if (e_pov) begin
        n_cmp++;
        if (resp_out_msg !== resp_in_msg) begin
          n_fail++;
          $display("FAIL rand_msg cyc %0d: got %h expected %h", c, resp_out_msg, resp_in_msg);
        end
      end
      rs_f = resp_in_val && e_pir;
      rq_f = req_in_val && e_rir;
      if (rs_f) begin
        if (!e_pov) model_dropped++;
        void'(live_q.pop_front());
      end
      if (squash) foreach (live_q[k]) live_q[k] = 1'b0;
      if (rq_f) live_q.push_back(1'b1);
    end
    step(); idle(); #1;
    n_dead = 0;
    foreach (live_q[k]) if (!live_q[k]) n_dead++;
    n_cmp++;
    if (int'(dut.inflight_q) !== live_q.size() || int'(dut.drop_cnt_q) !== n_dead) begin
      n_fail++;
      $display("FAIL rand_state: got inflight %0d drop %0d expected %0d %0d",
               dut.inflight_q, dut.drop_cnt_q, live_q.size(), n_dead);
    end
`ifdef LAB2_PROC_IMEM_DROP_STATS_EN
    n_cmp++;
    if (num_dropped !== 32'(model_dropped)) begin
      n_fail++;
      $display("FAIL rand_num_dropped: got %0d expected %0d", num_dropped, model_dropped);
    end
`endif
    do_reset();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_pass_through();
    test_credit_limit();
    test_squash();
    test_squash_coincident();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
